// File: rtl/sha256d_sequencer.sv
// Drives one SHA-256 compression core through the three passes of a Bitcoin double hash
// of a 640-bit header, carrying chaining values between passes and returning the digest.
module sha256d_sequencer #(
  parameter int WD_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hdr_valid,
  output logic         hdr_ready,
  input  logic [639:0] header,
  output logic         core_start,
  output logic [511:0] core_block,
  output logic [255:0] core_state_in,
  input  logic         core_done,
  input  logic [255:0] core_digest,
  output logic [1:0]   hash_count,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest,
  output logic         err,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {IDLE, S0, W0, S1, W1, S2, W2, OUT} state_t;

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam int WDW = (WD_CYCLES < 2) ? 1 : $clog2(WD_CYCLES);
  localparam logic [WDW-1:0] WD_LAST = WDW'(WD_CYCLES - 1);
  localparam bit WD_EN = (WD_CYCLES != 0);

  state_t         state;
  logic [127:0]   hdr_lo;
  logic [WDW-1:0] wd_cnt;

  // Handshakes: a header moves on the cycle hdr_valid and hdr_ready are both high, a digest
  // on the cycle out_valid and out_ready are both high; valid never drops before its transfer.
  assign hdr_ready = (state == IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      hdr_lo        <= '0;
      wd_cnt        <= '0;
      core_start    <= 1'b0;
      core_block    <= '0;
      core_state_in <= '0;
      hash_count    <= 2'd0;
      out_valid     <= 1'b0;
      digest        <= '0;
      err           <= 1'b0;
    end else begin
      core_start <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (hdr_valid) begin
            hdr_lo        <= header[127:0];
            core_block    <= header[639:128];
            core_state_in <= IV;
            hash_count    <= 2'd0;
            core_start    <= 1'b1;
            state         <= S0;
          end
        end
        S0: begin
          wd_cnt <= '0;
          state  <= W0;
        end
        S1: begin
          wd_cnt <= '0;
          state  <= W1;
        end
        S2: begin
          wd_cnt <= '0;
          state  <= W2;
        end
        W0, W1, W2: begin
          // A core answer on the expiry cycle still counts as a completion.
          if (core_done) begin
            case (state)
              W0: begin
                core_block    <= {hdr_lo, 1'b1, 319'b0, 64'd640};
                core_state_in <= core_digest;
                hash_count    <= 2'd1;
                core_start    <= 1'b1;
                state         <= S1;
              end
              W1: begin
                core_block    <= {core_digest, 1'b1, 191'b0, 64'd256};
                core_state_in <= IV;
                hash_count    <= 2'd2;
                core_start    <= 1'b1;
                state         <= S2;
              end
              default: begin
                digest    <= core_digest;
                out_valid <= 1'b1;
                state     <= OUT;
              end
            endcase
          end else if (WD_EN && wd_cnt == WD_LAST) begin
            err        <= 1'b1;
            hash_count <= 2'd0;
            state      <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256d_sequencer.sv
// Bench for sha256d_sequencer: SHA-256 core model, reference double-hash model,
// digest/latency scoreboard, backpressure, watchdog and mid-run reset scenarios.
module tb_sha256d_sequencer;

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [639:0] GEN_HDR = {32'h01000000, 256'h0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
    32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
  localparam logic [255:0] GEN_DIGEST =
    256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef struct {
    logic [511:0] blk;
    logic [255:0] st;
    logic [1:0]   pass;
  } blk_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         hdr_valid, hdr_ready, core_start, core_done, out_valid, out_ready, err;
  logic [639:0] header;
  logic [511:0] core_block;
  logic [255:0] core_state_in, core_digest, digest;
  logic [1:0]   hash_count;
  logic [2:0]   dbg_state;

  logic         wd_hdr_valid, wd_hdr_ready, wd_core_start, wd_core_done, wd_out_valid, wd_err;
  logic         wd_out_ready;
  logic [511:0] wd_core_block;
  logic [255:0] wd_core_state_in, wd_core_digest, wd_digest;
  logic [1:0]   wd_hash_count;
  logic [2:0]   wd_dbg_state;

  sha256d_sequencer dut (
    .clk(clk), .rst(rst), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .header(header),
    .core_start(core_start), .core_block(core_block), .core_state_in(core_state_in),
    .core_done(core_done), .core_digest(core_digest), .hash_count(hash_count),
    .out_valid(out_valid), .out_ready(out_ready), .digest(digest), .err(err),
    .dbg_state(dbg_state));

  sha256d_sequencer #(.WD_CYCLES(8)) dut_wd (
    .clk(clk), .rst(rst), .hdr_valid(wd_hdr_valid), .hdr_ready(wd_hdr_ready), .header(header),
    .core_start(wd_core_start), .core_block(wd_core_block), .core_state_in(wd_core_state_in),
    .core_done(wd_core_done), .core_digest(wd_core_digest), .hash_count(wd_hash_count),
    .out_valid(wd_out_valid), .out_ready(wd_out_ready), .digest(wd_digest), .err(wd_err),
    .dbg_state(wd_dbg_state));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int core_lat = 1;
  int ready_mode = 0;
  bit abort = 1'b0;
  logic [255:0] exp_q[$];
  int           exp_cyc_q[$];
  blk_t         blk_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference SHA-256
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
            e + hin[127:96], f + hin[95:64], g + hin[63:32], h + hin[31:0]};
  endfunction

  // message is MSB-aligned in a 1024-bit buffer, unused bits zero
  function automatic logic [1023:0] pad(input logic [1023:0] m, input int len);
    logic [1023:0] p;
    int nblk;
    p = m;
    p[1023 - len] = 1'b1;
    nblk = (len + 65 + 511) / 512;
    p[1024 - nblk*512 +: 64] = 64'(len);
    return p;
  endfunction

  function automatic logic [255:0] sha256(input logic [1023:0] m, input int len);
    logic [1023:0] p;
    logic [255:0] h;
    int nblk;
    p = pad(m, len);
    nblk = (len + 65 + 511) / 512;
    h = IV;
    for (int b = 0; b < nblk; b++) h = compress(h, p[1023 - 512*b -: 512]);
    return h;
  endfunction

  // SHA-256 compression core model with configurable latency
  initial begin
    blk_t e;
    logic [511:0] b;
    logic [255:0] s, d;
    int lat;
    bit moved;
    core_done = 1'b0;
    core_digest = '0;
    @(posedge clk); #1;
    forever begin
      if (core_start === 1'b1) begin
        b = core_block; s = core_state_in; lat = core_lat;
        d = compress(s, b);
        if (blk_q.size() == 0) chk("core_start_unexpected", 1, 0);
        else begin
          e = blk_q.pop_front();
          chk("core_block", b, e.blk);
          chk("core_state_in", s, e.st);
          chk("hash_count", hash_count, e.pass);
          if (e.pass == 2'd1) begin
            chk("s1_zero_gap", b[191:64], 0);
            chk("s1_len", b[63:0], 64'h280);
            chk("s1_pad_bit", b[383], 1);
          end
          if (e.pass == 2'd2) begin
            chk("s2_len", b[63:0], 64'h100);
            chk("s2_pad_bit", b[255], 1);
            chk("s2_state_iv", s, IV);
          end
        end
        moved = 1'b0;
        @(posedge clk); #1;
        chk("core_start_pulse", core_start, 0);
        for (int i = 1; i < lat; i++) begin
          if (core_block !== b || core_state_in !== s) moved = 1'b1;
          @(posedge clk); #1;
        end
        if (core_block !== b || core_state_in !== s) moved = 1'b1;
        if (!abort) chk("operands_stable", moved, 0);
        core_done = 1'b1;
        core_digest = d;
        @(posedge clk); #1;
        core_done = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  // downstream backpressure: 0 always ready, 1 random, 2 stalled
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // monitor: latency at out_valid rise, digest at transfer
  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) ov_prev <= 1'b0;
    else begin
      if (out_valid && !ov_prev) begin
        if (exp_cyc_q.size() == 0) chk("out_valid_unexpected", 1, 0);
        else chk("latency_cycle", cyc, exp_cyc_q.pop_front());
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("digest_unexpected", 1, 0);
        else chk("digest", digest, exp_q.pop_front());
      end
      ov_prev <= out_valid;
    end
  end

  // driver: offer one header, push expected passes/digest/latency on acceptance
  task automatic send(input logic [639:0] h, input int lat, input bit genesis);
    logic [1023:0] p0, p2;
    logic [255:0] h1, mid;
    blk_t e;
    int n;
    p0 = pad({h, 384'b0}, 640);
    mid = compress(IV, p0[1023:512]);
    h1 = sha256({h, 384'b0}, 640);
    p2 = pad({h1, 768'b0}, 256);
    n = 0;
    @(negedge clk);
    while (!hdr_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      chk("hdr_ready_timeout", 0, 1);
      return;
    end
    core_lat = lat;
    header = h;
    hdr_valid = 1'b1;
    e.blk = p0[1023:512]; e.st = IV;  e.pass = 2'd0; blk_q.push_back(e);
    e.blk = p0[511:0];    e.st = mid; e.pass = 2'd1; blk_q.push_back(e);
    e.blk = p2[1023:512]; e.st = IV;  e.pass = 2'd2; blk_q.push_back(e);
    exp_q.push_back(genesis ? GEN_DIGEST : sha256({h1, 768'b0}, 256));
    exp_cyc_q.push_back(cyc + 3*(lat + 1) + 1);
    @(posedge clk); #1;
    hdr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !hdr_ready) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("drain_timeout", 0, 1);
  endtask

  function automatic logic [639:0] rand_hdr();
    logic [639:0] h;
    for (int j = 0; j < 20; j++) h[j*32 +: 32] = $urandom();
    return h;
  endfunction

  initial begin
    logic [255:0] cap;
    int n, acc;
    bit sc;
    rst = 1'b1;
    hdr_valid = 1'b0;
    header = '0;
    wd_hdr_valid = 1'b0;
    wd_core_done = 1'b0;
    wd_core_digest = '0;
    wd_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {hdr_ready, core_start, out_valid, err, hash_count}, 6'b100000);
    chk("rst_digest", digest, 0);
    chk("rst_block", core_block, 0);
    chk("rst_state_in", core_state_in, 0);
    chk("rst_wd_ctrl", {wd_hdr_ready, wd_core_start, wd_out_valid, wd_err}, 4'b1000);
    @(posedge clk); #1;
    rst = 1'b0;

    // genesis block with fast and slow cores
    send(GEN_HDR, 1, 1'b1);
    wait_idle();
    send(GEN_HDR, 70, 1'b1);
    wait_idle();

    // random headers, back to back, random backpressure
    ready_mode = 1;
    for (int i = 0; i < 6; i++) send(rand_hdr(), (i == 2) ? 40 : $urandom_range(1, 6), 1'b0);
    wait_idle();

    // stalled downstream
    ready_mode = 2;
    repeat (2) @(negedge clk);
    send(GEN_HDR, 1, 1'b1);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("hold_out_valid_seen", out_valid, 1);
    cap = digest;
    repeat (20) begin
      @(negedge clk);
      chk("hold_stable", {out_valid, hdr_ready, digest}, {1'b1, 1'b0, cap});
    end
    ready_mode = 0;
    @(negedge clk);
    chk("hold_transfer_cycle", {out_valid, out_ready, hdr_ready}, 3'b110);
    @(negedge clk);
    chk("ready_after_xfer", {hdr_ready, out_valid}, 2'b10);
    wait_idle();

    // watchdog: core never answers
    @(negedge clk);
    chk("wd_ready", wd_hdr_ready, 1);
    header = rand_hdr();
    wd_hdr_valid = 1'b1;
    acc = cyc;
    @(posedge clk); #1;
    wd_hdr_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("wd_err", wd_err, (cyc == acc + 10));
      chk("wd_hdr_ready", wd_hdr_ready, (k >= 10));
      if (k == 1) begin
        chk("wd_start", {wd_core_start, wd_hash_count, wd_out_valid}, 4'b1000);
        chk("wd_block0", wd_core_block, header[639:128]);
        chk("wd_state_iv", wd_core_state_in, IV);
      end
    end
    @(posedge clk); #1;
    wd_core_done = 1'b1;
    @(posedge clk); #1;
    wd_core_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("wd_spurious_done", {wd_core_start, wd_hdr_ready, wd_out_valid, wd_err, wd_dbg_state},
          {4'b0100, 3'd0});
    end
    chk("wd_digest_untouched", wd_digest, 0);

    // reset during the second pass
    ready_mode = 0;
    send(rand_hdr(), 5, 1'b0);
    n = 0;
    @(negedge clk);
    while (!(hash_count == 2'd1 && !core_start) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_w1", hash_count, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_ctrl", {hdr_ready, core_start, out_valid, err, hash_count, dbg_state}, 9'b100000000);
    chk("rst_mid_digest", digest, 0);
    chk("rst_mid_block", core_block, 0);
    chk("rst_mid_state_in", core_state_in, 0);
    exp_q.delete();
    exp_cyc_q.delete();
    blk_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    sc = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (core_start || !hdr_ready || out_valid) sc = 1'b1;
    end
    chk("stale_done_ignored", sc, 0);
    abort = 1'b0;
    send(rand_hdr(), 3, 1'b0);
    wait_idle();
    send(GEN_HDR, 2, 1'b1);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("queues_empty", exp_q.size() + exp_cyc_q.size() + blk_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    bad++;
    $display("FAIL global_timeout: got running want finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
